// File: rtl/gumnut_io_ports.sv
// Gumnut port-bus I/O controller: registered output channels, synchronised
// input channels with change-detect interrupts, cyc/stb/ack handshake.
module gumnut_io_ports #(
  parameter int unsigned        DATA_W      = 8,
  parameter int unsigned        ADDR_W      = 8,
  parameter int unsigned        N_OUT       = 4,
  parameter int unsigned        N_IN        = 4,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  OUT_RST     = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     port_cyc_i,
  input  logic                     port_stb_i,
  input  logic                     port_we_i,
  input  logic [ADDR_W-1:0]        port_adr_i,
  input  logic [DATA_W-1:0]        port_dat_i,
  output logic [DATA_W-1:0]        port_dat_o,
  output logic                     port_ack_o,
  input  logic [N_IN*DATA_W-1:0]   pins_i,
  output logic [N_OUT*DATA_W-1:0]  pins_o,
  output logic [N_OUT-1:0]         wr_pulse_o,
  output logic                     int_req_o
);

  localparam int unsigned MASK_A  = N_OUT + N_IN;
  localparam int unsigned PEND_A  = N_OUT + N_IN + 1;
  localparam int unsigned PRIME_N = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(PRIME_N + 1);

  if (N_IN > DATA_W) begin : g_chk_in
    $error("N_IN must not exceed DATA_W");
  end
  if ((ADDR_W < 31) && ((N_OUT + N_IN + 2) > (32'd1 << ADDR_W))) begin : g_chk_addr
    $error("address map does not fit in ADDR_W");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic                      ack_q, ack_d;
  logic [DATA_W-1:0]         dat_q, dat_d;
  logic [N_OUT*DATA_W-1:0]   out_q, out_d;
  logic [N_OUT-1:0]          wr_q, wr_d;
  logic [N_IN-1:0]           mask_q, mask_d;
  logic [N_IN-1:0]           pend_q, pend_d;
  logic                      int_q, int_d;
  logic [CNT_W-1:0]          prime_q, prime_d;
  logic [N_IN*DATA_W-1:0]    sync_q [SYNC_STAGES];
  logic [N_IN*DATA_W-1:0]    prev_q;
  logic [N_IN*DATA_W-1:0]    synced_s;
  logic [N_IN-1:0]           change_s;
  logic [N_IN-1:0]           clr_s;
  logic [DATA_W-1:0]         rd_s;
  logic                      primed_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Change detection, held off until the synchroniser pipeline has filled.
  always_comb begin
    primed_s = (prime_q == CNT_W'(PRIME_N));
    prime_d  = primed_s ? prime_q : (prime_q + CNT_W'(1));
    change_s = '0;
    for (int k = 0; k < N_IN; k++) begin
      change_s[k] = primed_s && (synced_s[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
    end
  end

  // Read-data multiplexer over the address map; unmapped addresses read 0.
  always_comb begin
    rd_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (port_adr_i == ADDR_W'(k)) rd_s = out_q[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (port_adr_i == ADDR_W'(N_OUT + k)) rd_s = synced_s[k*DATA_W +: DATA_W];
    end
    if (port_adr_i == ADDR_W'(MASK_A)) begin
      rd_s = DATA_W'(mask_q);
    end else if (port_adr_i == ADDR_W'(PEND_A)) begin
      rd_s = DATA_W'(pend_q);
    end else begin
      rd_s = rd_s;
    end
  end

  // Handshake FSM and register-file next state.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    out_d   = out_q;
    wr_d    = '0;
    mask_d  = mask_q;
    clr_s   = '0;
    int_d   = |(pend_q & mask_q);
    case (state_q)
      ST_IDLE: begin
        if (port_cyc_i && port_stb_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (port_we_i) begin
            for (int k = 0; k < N_OUT; k++) begin
              if (port_adr_i == ADDR_W'(k)) begin
                out_d[k*DATA_W +: DATA_W] = port_dat_i;
                wr_d[k]                   = 1'b1;
              end
            end
            if (port_adr_i == ADDR_W'(MASK_A)) begin
              mask_d = port_dat_i[N_IN-1:0];
            end else if (port_adr_i == ADDR_W'(PEND_A)) begin
              clr_s = port_dat_i[N_IN-1:0];
            end else begin
              clr_s = '0;
            end
          end else begin
            dat_d = rd_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new change on the clearing edge keeps the bit set.
    pend_d = (pend_q & ~clr_s) | change_s;
  end

  // Bus, output and interrupt state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= {N_OUT{OUT_RST}};
      wr_q    <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      int_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
      prime_q <= prime_d;
    end
  end

  // Input synchroniser chain and previous-value compare register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pins_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= synced_s;
    end
  end

  assign port_ack_o = ack_q;
  assign port_dat_o = dat_q;
  assign pins_o     = out_q;
  assign wr_pulse_o = wr_q;
  assign int_req_o  = int_q;

endmodule
